forward_hazard_ctrl: RTL
========================

Name: forward_hazard_ctrl

Overview:
- Control-side counterpart of the 3-input EX-stage operand forwarding mux in the 5-stage RISC-V pipeline.
- Tracks destination-register info for instructions in EX, MEM and WB in its own shadow pipeline.
- Drives the mux select codes for both ALU operands, detects load-use hazards (stall plus bubble) and taken-branch flushes.

Parameters:
- REG_ADDR_W, 5, register index width.
- STAT_W, 32, statistics counter width (optional feature only).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  REG_ADDR_W  ID source register 1
- id_rs2  in  REG_ADDR_W  ID source register 2
- id_rd  in  REG_ADDR_W  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- forward_a  out  2  select for operand A mux
- forward_b  out  2  select for operand B mux
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- flush  out  1  squash IF/ID and ID/EX

Behaviour:
- Select encoding is shared with the mux: 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result; 11 is never driven.
- Internal stage entries EX, MEM, WB each hold: valid, rd, reg_write, mem_read. The EX entry also holds rs1 and rs2.
- Reset (async, immediate):
  - all entries cleared (valid=0, fields 0).
  - forward_a/b=00, stall=0, flush=0.
  - Outputs stay at these values until the first valid ID entry advances.
- Every rising clk edge, outside reset:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields when stall=0 and flush=0; otherwise EX<=bubble (valid=0, reg_write=0).
- Stage entries and the ID inputs update only on this edge; the outputs below are combinational from them (zero added latency). A bubble inserted into EX therefore produces no forwarding in that cycle or later.
- Forwarding for EX rs1; rs2 is identical, driving forward_b:
  - 10 if MEM.valid and MEM.reg_write and MEM.rd != 0 and MEM.rd == EX.rs1.
  - else 01 if WB.valid and WB.reg_write and WB.rd != 0 and WB.rd == EX.rs1.
  - else 00.
  - EX/MEM has priority over MEM/WB (youngest producer wins).
  - x0 is never forwarded.
- Load-use stall:
  - stall=1 when EX.valid and EX.mem_read and EX.rd != 0 and id_valid and (EX.rd == id_rs1 or EX.rd == id_rs2).
  - One stall cycle per load. The next cycle the load is in MEM, the forwarding path covers it (MEM/WB), and stall drops.
- Flush:
  - flush = ex_branch_taken and EX.valid.
  - Flush overrides stall: stall forced 0 while flush=1.
  - The branch itself advances to MEM normally.
- Same-cycle WB write vs ID read is resolved by the write-first register file. It is not this block's concern.
- Back-to-back loads to the same rd: each load stalls independently.
- Reset mid-stall or mid-flush: all pending state is discarded; the bubble is not retained.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds outputs stall_count and flush_count, each STAT_W bits.
  - Each increments on each clk edge where stall (resp. flush) is 1.
  - Both saturate at all-ones.
  - Both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package, hazard_pkg:
  - select constants FWD_REGFILE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10.
  - stage-entry struct type (valid, rd, reg_write, mem_read).
- One natural sub-module, forward_select: per-operand priority comparator. Instantiated twice (rs1, rs2), purely combinational.
- Shadow pipeline, stall and flush logic stay in the top.

Test Plan:
- Reset then idle: forward_a=forward_b=00, stall=0, flush=0 for 5 cycles.
- EX/MEM forward: addi x5 issued, then add x6,x5,x7 next cycle → when add is in EX, forward_a=10, forward_b=00.
- MEM/WB forward and priority:
  - Writer x5, independent instruction, then reader of x5 in rs2 → forward_b=01.
  - With two writers of x5 back-to-back → forward_b=10.
- Load-use: lw x8 in EX, ID has rs1=8 → stall=1 for exactly 1 cycle. The next cycle EX is a bubble, and the reader's EX cycle shows forward_a=01.
- x0 filter: writer with rd=0 and reg_write=1, followed by reader rs1=0 → forward_a=00. A load to rd=0 never raises stall.
- Flush over stall:
  - Setup: load-use condition plus ex_branch_taken=1 with EX.valid=1 → flush=1, stall=0, and EX receives a bubble next cycle.
  - With HAZARD_STATS_EN: flush_count increments by 1, stall_count unchanged.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the EX-stage forwarding / hazard control slice.
//   RD_W         : register index width carried in a stage entry
//   FWD_*        : operand-mux select codes (shared with the datapath mux)
//   stage_t      : per-stage destination info tracked by the shadow pipeline
//   STAGE_EMPTY  : cleared entry, also used as the bubble pattern
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int RD_W = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            reg_write;
        logic            mem_read;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

endpackage

// File: rtl/forward_hazard_ctrl_forward_select.sv
// -----------------------------------------------------------------------------
// forward_select
// Per-operand priority comparator, purely combinational.
//   mem_stage : entry currently in MEM (EX/MEM register producer)
//   wb_stage  : entry currently in WB  (MEM/WB register producer)
//   rs        : source register of the instruction in EX
//   sel       : FWD_EXMEM if MEM produces rs, else FWD_MEMWB if WB does,
//               else FWD_REGFILE. x0 never matches.
// -----------------------------------------------------------------------------
module forward_select
    import hazard_pkg::*;
(
    input  stage_t          mem_stage,
    input  stage_t          wb_stage,
    input  logic [RD_W-1:0] rs,
    output logic [1:0]      sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_stage.valid && mem_stage.reg_write &&
                     (mem_stage.rd != '0) && (mem_stage.rd == rs);
    assign wb_hit  = wb_stage.valid && wb_stage.reg_write &&
                     (wb_stage.rd != '0) && (wb_stage.rd == rs);

    // Load flags are irrelevant to forwarding once the load has left EX.
    logic unused_mem_read;
    assign unused_mem_read = &{1'b0, mem_stage.mem_read, wb_stage.mem_read};

    // Youngest producer wins.
    always_comb begin
        sel = FWD_REGFILE;
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// forward_hazard_ctrl
// Control side of the EX-stage 3-input operand forwarding mux. Keeps a shadow
// copy of destination info for EX, MEM and WB, and derives forwarding
// selects, load-use stall and taken-branch flush combinationally from it.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   id_valid            : ID holds a real instruction
//   id_rs1/id_rs2/id_rd : ID register indices
//   id_reg_write        : ID instruction writes rd
//   id_mem_read         : ID instruction is a load
//   ex_branch_taken     : branch/jump in EX resolved taken
//   forward_a/forward_b : operand A/B mux selects (00 rf, 01 MEM/WB, 10 EX/MEM)
//   stall               : hold PC and IF/ID, bubble into ID/EX
//   flush               : squash IF/ID and ID/EX
//
// Optional build macro HAZARD_STATS_EN adds stall_count / flush_count
// (STAT_W bits, saturating) counting cycles with stall / flush asserted.
//
// REG_ADDR_W must match hazard_pkg::RD_W, which sizes the stage entries.
// -----------------------------------------------------------------------------
module forward_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
`ifdef HAZARD_STATS_EN
    ,
    parameter int STAT_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
`ifdef HAZARD_STATS_EN
    output logic [STAT_W-1:0]     stall_count,
    output logic [STAT_W-1:0]     flush_count,
`endif
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall,
    output logic                  flush
);

    stage_t                ex_reg, mem_reg, wb_reg;
    stage_t                ex_next;
    logic [REG_ADDR_W-1:0] ex_rs_reg  [2];
    logic [REG_ADDR_W-1:0] ex_rs_next [2];
    logic [1:0]            fwd_sel    [2];
    logic                  load_use;

    // ---------------- hazard detection ----------------
    assign flush    = ex_branch_taken && ex_reg.valid;
    assign load_use = ex_reg.valid && ex_reg.mem_read && (ex_reg.rd != '0) &&
                      id_valid && ((ex_reg.rd == id_rs1) || (ex_reg.rd == id_rs2));
    // A flush squashes the dependent instruction anyway, so it wins.
    assign stall    = load_use && !flush;

    // ---------------- EX entry selection ----------------
    always_comb begin
        ex_next       = STAGE_EMPTY;
        ex_rs_next[0] = '0;
        ex_rs_next[1] = '0;
        if (!stall && !flush) begin
            ex_next.valid     = id_valid;
            ex_next.rd        = id_rd;
            ex_next.reg_write = id_reg_write;
            ex_next.mem_read  = id_mem_read;
            ex_rs_next[0]     = id_rs1;
            ex_rs_next[1]     = id_rs2;
        end
    end

    // ---------------- shadow pipeline ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_reg       <= STAGE_EMPTY;
            mem_reg      <= STAGE_EMPTY;
            wb_reg       <= STAGE_EMPTY;
            ex_rs_reg[0] <= '0;
            ex_rs_reg[1] <= '0;
        end else begin
            ex_reg       <= ex_next;
            mem_reg      <= ex_reg;
            wb_reg       <= mem_reg;
            ex_rs_reg[0] <= ex_rs_next[0];
            ex_rs_reg[1] <= ex_rs_next[1];
        end
    end

    // ---------------- forwarding selects (0 = rs1, 1 = rs2) ----------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            forward_select u_forward_select (
                .mem_stage (mem_reg),
                .wb_stage  (wb_reg),
                .rs        (ex_rs_reg[gi]),
                .sel       (fwd_sel[gi])
            );
        end
    endgenerate

    assign forward_a = fwd_sel[0];
    assign forward_b = fwd_sel[1];

`ifdef HAZARD_STATS_EN
    // ---------------- saturating event counters ----------------
    logic [STAT_W-1:0] stall_count_reg;
    logic [STAT_W-1:0] flush_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (stall && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
            if (flush && (flush_count_reg != '1)) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end

    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;
`endif

endmodule
